// File: rtl/rv_mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Fixed 32-cycle latency from accept to the one-cycle done/we pulse; start is ignored while busy.
module rv_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic        a_neg, b_neg;
  logic [31:0] hi, lo, bmag;

  logic        a_sgn, b_sgn, a_in_neg, b_in_neg;
  logic [31:0] a_in_mag, b_in_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] hi_nxt, lo_nxt;
  logic [63:0] prod, prod_fix;
  logic [31:0] quot, rem, res_nxt;

  // Signedness decode; magnitudes are formed at accept so the iteration is always unsigned
  always_comb begin
    a_sgn    = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    b_sgn    = a_sgn && (funct3 != 3'b010);
    a_in_neg = a_sgn && rs1_data[31];
    b_in_neg = b_sgn && rs2_data[31];
    a_in_mag = a_in_neg ? -rs1_data : rs1_data;
    b_in_mag = b_in_neg ? -rs2_data : rs2_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // One iteration: {hi,lo} is the product shifter, or {remainder, quotient/dividend}
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : 33'd0);
    div_shift = {hi, lo[31]};
    div_ge    = div_shift >= {1'b0, bmag};
    if (op[2]) begin
      hi_nxt = div_ge ? (div_shift[31:0] - bmag) : div_shift[31:0];
      lo_nxt = {lo[30:0], div_ge};
    end else begin
      hi_nxt = mul_sum[32:1];
      lo_nxt = {mul_sum[0], lo[31:1]};
    end
  end

  // Divide-by-zero needs only the quotient forced; the remainder falls out as the dividend
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    quot     = (bmag == 32'd0) ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -lo_nxt : lo_nxt);
    rem      = a_neg ? -hi_nxt : hi_nxt;
    case (op)
      3'b000:                 res_nxt = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod_fix[63:32];
      3'b100, 3'b101:         res_nxt = quot;
      default:                res_nxt = rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 5'd0;
      op     <= 3'd0;
      rd_q   <= 5'd0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      bmag   <= 32'd0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= 5'd0;
          op    <= funct3;
          rd_q  <= rd_in;
          a_neg <= a_in_neg;
          b_neg <= b_in_neg;
          hi    <= 32'd0;
          lo    <= a_in_mag;
          bmag  <= b_in_mag;
        end
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result <= res_nxt;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign we   = done;

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: directed ops push expected result/rd/done-cycle, a negedge monitor pops on done.
module tb_rv_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  rv_mdu dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] cyc;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("we_equals_done", 32'(we), 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result_op%0d", mon_e.id), result, mon_e.res);
        chk($sformatf("rd_out_op%0d", mon_e.id), 32'(rd_out), 32'(mon_e.rd));
        chk($sformatf("latency_op%0d", mon_e.id), 32'(cyc), mon_e.cyc);
      end
    end
  end

  task automatic wait_idle(input logic [7:0] id);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("idle_timeout_op%0d", id), 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv, input logic [7:0] id);
    @(posedge clk);
    #1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    sb.push_back('{expv, rd, 32'(cyc + 33), id});
    @(posedge clk);
    #1;
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    funct3   = 3'($urandom);
    rd_in    = 5'($urandom);
    wait_idle(id);
    chk($sformatf("hold_op%0d", id), result, expv);
  endtask

  int c0;

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    #2 reset = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", 32'(rd_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 8'd1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 8'd2);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 8'd3);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 8'd4);
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 8'd5);
    issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 8'd6);
    issue(3'b101, 32'h0000_0007, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF, 8'd7);
    issue(3'b111, 32'h0000_0007, 32'h0000_0000, 5'd13, 32'h0000_0007, 8'd8);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 8'd9);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 8'd10);
    issue(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd16, 32'h2345_6780, 8'd11);
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 5'd17, 32'hFFFF_FFFF, 8'd12);
    issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 5'd18, 32'hFFFF_FFF9, 8'd13);
    issue(3'b111, 32'h0000_0064, 32'h0000_0007, 5'd19, 32'h0000_0002, 8'd14);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 8'd15);

    // start held for 40 cycles: first op uses its accept-edge operands, re-accept two edges after done
    @(posedge clk);
    #1;
    c0 = cyc;
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9; start = 1'b1;
    sb.push_back('{32'd14, 5'd9, 32'(c0 + 33), 8'd50});
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      funct3   = 3'b000;
      rs1_data = 32'(100 + i);
      rs2_data = 32'd3;
      rd_in    = 5'(i);
    end
    sb.push_back('{32'd399, 5'd1, 32'(c0 + 67), 8'd51});
    start = 1'b0;
    wait_idle(8'd51);
    chk("hold_op51", result, 32'd399);

    // reset in the middle of an operation: immediate clear, no done for the aborted op
    @(posedge clk);
    #1;
    funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd22; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_rd_out", 32'(rd_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle", 32'(busy), 32'd0);
    issue(3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 8'd60);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
